// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: target side of the cpu memory bus. One access per
// machine cycle (ct 0..3): address latched at the ct==1 edge, RAM read at the
// ct==2 edge, data/write committed at the ct==3 edge. Owns IF, IE and JOYP.
//
// Strobe protocol: rd/wr are level strobes held for the whole machine cycle.
// A cycle starts only at a ct==1 edge with rd|wr high; dropping both strobes
// before the ct==3 edge aborts it (no write, din untouched).
module cpu_bus_responder #(
  parameter int WRAM_AW = 13,
  parameter int ROM_AW  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ct,
  input  logic [15:0]       a,
  input  logic [7:0]        cpu_dout,
  input  logic              rd,
  input  logic              wr,
  output logic [7:0]        din,
  output logic [4:0]        int_en,
  output logic [4:0]        int_flags,
  input  logic [4:0]        int_ack,
  input  logic [4:0]        irq_req,
  input  logic [7:0]        buttons,
  output logic [7:0]        key_out,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              bus_err,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         latch_addr, ram_rd_en, commit;
  logic [15:0]  a_q;
  logic [7:0]   wram [0:(2**WRAM_AW)-1];
  logic [7:0]   hram [0:126];
  logic [7:0]   wram_q, hram_q;
  logic [4:0]   if_q, ie_q;
  logic [1:0]   sel_q;
  logic [3:0]   nib, nib_q;
  logic         joy_irq;
  logic         is_rom, is_wram, is_hram, is_joyp, is_if, is_ie;
  logic         wr_commit;
  logic [7:0]   rd_data;

  assign fsm_state = state_q;
  assign int_en    = ie_q;
  assign int_flags = if_q;

  // State register; reset mid-cycle drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and per-edge control strobes.
  always_comb begin
    state_d    = state_q;
    latch_addr = 1'b0;
    ram_rd_en  = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ct == 2'd1 && (rd || wr)) begin
          state_d    = ADDR;
          latch_addr = 1'b1;
        end
      end
      ADDR: begin
        if (!(rd || wr)) begin
          state_d = IDLE;
        end else begin
          state_d   = DATA;
          ram_rd_en = 1'b1;
        end
      end
      DATA: begin
        if (!(rd || wr)) begin
          state_d = IDLE;
        end else if (ct == 2'd3) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address decode of the latched address.
  always_comb begin
    is_rom  = (a_q[15] == 1'b0);
    is_wram = (a_q[15:13] == 3'b110);
    is_hram = (a_q[15:7] == 9'h1FF) && (a_q[6:0] != 7'h7F);
    is_joyp = (a_q == 16'hFF00);
    is_if   = (a_q == 16'hFF0F);
    is_ie   = (a_q == 16'hFFFF);
  end

  // Joypad nibble: active-low, a cleared select bit enables its button group.
  always_comb begin
    nib = 4'hF;
    if (!sel_q[0]) nib = nib & ~buttons[3:0];
    if (!sel_q[1]) nib = nib & ~buttons[7:4];
    key_out = {2'b11, sel_q, nib};
    joy_irq = |(nib_q & ~nib);
  end

  // Read data mux for the committing edge.
  always_comb begin
    rd_data = 8'hFF;
    if (is_rom)        rd_data = rom_data;
    else if (is_wram)  rd_data = wram_q;
    else if (is_hram)  rd_data = hram_q;
    else if (is_joyp)  rd_data = key_out;
    else if (is_if)    rd_data = {3'b111, if_q};
    else if (is_ie)    rd_data = {3'b000, ie_q};
  end

  assign wr_commit = commit & wr;

  // Address latch and ROM address, captured when a cycle starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= 16'h0000;
      rom_addr <= '0;
    end else if (latch_addr) begin
      a_q      <= a;
      rom_addr <= a[ROM_AW-1:0];
    end
  end

  // RAM arrays: registered read one edge ahead of the commit, write at commit.
  always_ff @(posedge clk) begin
    if (ram_rd_en) begin
      wram_q <= wram[a_q[WRAM_AW-1:0]];
      hram_q <= hram[a_q[6:0]];
    end
    if (wr_commit && is_wram) wram[a_q[WRAM_AW-1:0]] <= cpu_dout;
    if (wr_commit && is_hram) hram[a_q[6:0]] <= cpu_dout;
  end

  // Read data, bus error pulse and register file; set beats clear in IF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din     <= 8'hFF;
      bus_err <= 1'b0;
      if_q    <= 5'd0;
      ie_q    <= 5'd0;
      sel_q   <= 2'b11;
      nib_q   <= 4'hF;
    end else begin
      bus_err <= commit & rd & wr;
      if (commit && rd) din <= wr ? 8'hFF : rd_data;
      if (wr_commit && is_if)
        if_q <= cpu_dout[4:0] | irq_req | {joy_irq, 4'b0000};
      else
        if_q <= (if_q & ~int_ack) | irq_req | {joy_irq, 4'b0000};
      if (wr_commit && is_ie)   ie_q  <= cpu_dout[4:0];
      if (wr_commit && is_joyp) sel_q <= cpu_dout[5:4];
      nib_q <= nib;
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: directed bus cycles against a memory-map model.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ct = 2'd0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  din;
  logic [4:0]  int_en, int_flags;
  logic [4:0]  int_ack = 5'd0;
  logic [4:0]  irq_req = 5'd0;
  logic [7:0]  buttons = 8'h00;
  logic [7:0]  key_out;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        bus_err;
  logic [1:0]  fsm_state;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  cpu_bus_responder #(.WRAM_AW(13), .ROM_AW(15)) dut (
    .clk(clk), .rst(rst), .ct(ct), .a(a), .cpu_dout(cpu_dout), .rd(rd), .wr(wr),
    .din(din), .int_en(int_en), .int_flags(int_flags), .int_ack(int_ack),
    .irq_req(irq_req), .buttons(buttons), .key_out(key_out), .rom_addr(rom_addr),
    .rom_data(rom_data), .bus_err(bus_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / cpu T-cycle counter ----------------
  always #5 clk = ~clk;
  always @(negedge clk) ct = ct + 2'd1;

  // External synchronous ROM: data follows the address one clock later.
  function automatic logic [7:0] rom_fn(input logic [14:0] ad);
    return ad[7:0] ^ {1'b0, ad[14:8]};
  endfunction
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // ---------------- behavioural model ----------------
  logic [7:0] mem_m [0:65535];
  logic [7:0] m_din = 8'hFF;
  logic [4:0] m_if = 5'd0, m_ie = 5'd0;
  logic [1:0] m_sel = 2'b11;
  logic [3:0] m_prev_nib = 4'hF;
  logic       m_bus_err = 1'b0;
  int         txn_seq = 0, m_done = 0;
  logic       txn_rd, txn_wr;
  logic [15:0] txn_addr;
  logic [7:0]  txn_data;
  logic [3:0]  m_n;
  logic        m_joy, m_ifw;
  logic [7:0]  m_rdv;

  function automatic logic [3:0] nib_of(input logic [1:0] s, input logic [7:0] b);
    logic [3:0] n = 4'hF;
    if (!s[0]) n = n & ~b[3:0];
    if (!s[1]) n = n & ~b[7:4];
    return n;
  endfunction

  function automatic logic [7:0] read_value(input logic [15:0] ad, input logic [3:0] n);
    if (ad < 16'h8000)                      return rom_fn(ad[14:0]);
    if (ad >= 16'hC000 && ad <= 16'hDFFF)   return mem_m[ad];
    if (ad >= 16'hFF80 && ad <= 16'hFFFE)   return mem_m[ad];
    if (ad == 16'hFF00)                     return {2'b11, m_sel, n};
    if (ad == 16'hFF0F)                     return {3'b111, m_if};
    if (ad == 16'hFFFF)                     return {3'b000, m_ie};
    return 8'hFF;
  endfunction

  // Model advances once per clock; a posted transaction completes on this edge.
  always @(posedge clk) begin
    if (!rst) begin
      m_din = 8'hFF; m_if = 5'd0; m_ie = 5'd0; m_sel = 2'b11;
      m_prev_nib = 4'hF; m_bus_err = 1'b0; m_done = txn_seq;
    end else begin
      m_n = nib_of(m_sel, buttons);
      m_joy = |(m_prev_nib & ~m_n);
      m_prev_nib = m_n;
      m_ifw = 1'b0;
      m_bus_err = 1'b0;
      if (txn_seq != m_done) begin
        m_done = txn_seq;
        m_rdv = read_value(txn_addr, m_n);
        if (txn_wr) begin
          if ((txn_addr >= 16'hC000 && txn_addr <= 16'hDFFF) ||
              (txn_addr >= 16'hFF80 && txn_addr <= 16'hFFFE)) mem_m[txn_addr] = txn_data;
          if (txn_addr == 16'hFF00) m_sel = txn_data[5:4];
          if (txn_addr == 16'hFFFF) m_ie = txn_data[4:0];
          if (txn_addr == 16'hFF0F) m_ifw = 1'b1;
        end
        if (txn_rd && txn_wr) begin
          m_din = 8'hFF;
          m_bus_err = 1'b1;
        end else if (txn_rd) begin
          m_din = m_rdv;
        end
      end
      if (m_ifw) m_if = txn_data[4:0] | irq_req | {m_joy, 4'b0000};
      else       m_if = (m_if & ~int_ack) | irq_req | {m_joy, 4'b0000};
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Every-cycle compare of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("din", {8'h00, din}, {8'h00, m_din});
      check("int_flags", {11'd0, int_flags}, {11'd0, m_if});
      check("int_en", {11'd0, int_en}, {11'd0, m_ie});
      check("key_out", {8'h00, key_out}, {8'h00, 2'b11, m_sel, nib_of(m_sel, buttons)});
      check("bus_err", {15'd0, bus_err}, {15'd0, m_bus_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_ct1();
    step();
    while (ct != 2'd1) step();
  endtask

  // Full machine cycle; returns just after the ct==3 commit edge.
  task automatic bus_cycle(input logic r, input logic w, input logic [15:0] ad,
                           input logic [7:0] d);
    wait_ct1();
    a = ad; rd = r; wr = w; cpu_dout = d;
    step();
    step();
    txn_rd = r; txn_wr = w; txn_addr = ad; txn_data = d;
    txn_seq++;
    step();
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] req, input logic [4:0] ack);
    step();
    irq_req = req; int_ack = ack;
    step();
    irq_req = 5'd0; int_ack = 5'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst = 1'b0;
    repeat (3) step();
    check("rst_din", {8'h00, din}, 16'h00FF);
    check("rst_if", {11'd0, int_flags}, 16'h0000);
    check("rst_ie", {11'd0, int_en}, 16'h0000);
    check("rst_key", {8'h00, key_out}, 16'h00FF);
    check("rst_bus_err", {15'd0, bus_err}, 16'h0000);
    rst = 1'b1;
    chk_en = 1'b1;

    // HRAM and unmapped space
    bus_cycle(1'b0, 1'b1, 16'hFF90, 8'hA5);
    bus_cycle(1'b1, 1'b0, 16'hFF90, 8'h00);
    check("hram_rd", {8'h00, din}, 16'h00A5);
    bus_cycle(1'b1, 1'b0, 16'hFEA0, 8'h00);
    check("unmapped_rd", {8'h00, din}, 16'h00FF);

    // WRAM
    bus_cycle(1'b0, 1'b1, 16'hC000, 8'h11);
    bus_cycle(1'b0, 1'b1, 16'hDFFF, 8'h99);
    bus_cycle(1'b0, 1'b1, 16'hC123, 8'h3C);
    bus_cycle(1'b1, 1'b0, 16'hDFFF, 8'h00);
    check("wram_top_rd", {8'h00, din}, 16'h0099);
    bus_cycle(1'b1, 1'b0, 16'hC123, 8'h00);
    bus_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    check("wram_base_rd", {8'h00, din}, 16'h0011);

    // ROM read, then a write that must be ignored
    bus_cycle(1'b1, 1'b0, 16'h1234, 8'h00);
    check("rom_addr", {1'b0, rom_addr}, 16'h1234);
    check("rom_rd", {8'h00, din}, 16'h0026);
    bus_cycle(1'b0, 1'b1, 16'h1234, 8'h55);
    bus_cycle(1'b1, 1'b0, 16'h1234, 8'h00);
    check("rom_wr_ignored", {8'h00, din}, 16'h0026);
    bus_cycle(1'b1, 1'b0, 16'h7FFF, 8'h00);

    // IE and IF registers
    bus_cycle(1'b0, 1'b1, 16'hFFFF, 8'hFF);
    check("ie_wr", {11'd0, int_en}, 16'h001F);
    bus_cycle(1'b1, 1'b0, 16'hFFFF, 8'h00);
    check("ie_rd", {8'h00, din}, 16'h001F);
    bus_cycle(1'b0, 1'b1, 16'hFF0F, 8'h03);
    bus_cycle(1'b1, 1'b0, 16'hFF0F, 8'h00);
    check("if_rd", {8'h00, din}, 16'h00E3);
    pulse(5'd0, 5'b00001);
    check("if_ack", {11'd0, int_flags}, 16'h0002);
    bus_cycle(1'b0, 1'b1, 16'hFF0F, 8'h00);
    pulse(5'b00100, 5'b00100);
    check("if_collision", {11'd0, int_flags}, 16'h0004);
    pulse(5'b01001, 5'd0);

    // Joypad: select directions, press right
    bus_cycle(1'b0, 1'b1, 16'hFF00, 8'h20);
    buttons = 8'h01;
    #1;
    check("joyp_key", {8'h00, key_out}, 16'h00EE);
    @(posedge clk); #2;
    check("joyp_irq", {11'd0, int_flags}, 16'h001D);
    bus_cycle(1'b1, 1'b0, 16'hFF00, 8'h00);
    check("joyp_rd", {8'h00, din}, 16'h00EE);
    step();
    buttons = 8'h10;
    step();
    buttons = 8'h00;
    bus_cycle(1'b0, 1'b1, 16'hFF00, 8'h10);
    buttons = 8'h10;
    step(); step();
    buttons = 8'h00;

    // rd & wr together: write happens, din forced to FF, one-clock bus_err
    bus_cycle(1'b1, 1'b1, 16'hC010, 8'h42);
    check("both_din", {8'h00, din}, 16'h00FF);
    check("both_err", {15'd0, bus_err}, 16'h0001);
    step();
    check("both_err_end", {15'd0, bus_err}, 16'h0000);
    bus_cycle(1'b1, 1'b0, 16'hC010, 8'h00);
    check("both_wr_done", {8'h00, din}, 16'h0042);

    // Abort: strobe dropped before the ct==3 edge
    wait_ct1();
    a = 16'hC000; wr = 1'b1; cpu_dout = 8'h77;
    step(); step();
    wr = 1'b0;
    step();
    bus_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    check("abort_no_wr", {8'h00, din}, 16'h0011);

    // Reset while in DATA: no write, registers back to reset values
    wait_ct1();
    a = 16'hC000; wr = 1'b1; cpu_dout = 8'h77;
    step(); step();
    rst = 1'b0;
    wr = 1'b0;
    step(); step();
    check("midrst_din", {8'h00, din}, 16'h00FF);
    check("midrst_ie", {11'd0, int_en}, 16'h0000);
    rst = 1'b1;
    bus_cycle(1'b1, 1'b0, 16'hC000, 8'h00);
    check("midrst_no_wr", {8'h00, din}, 16'h0011);
    bus_cycle(1'b1, 1'b0, 16'hFF90, 8'h00);
    check("hram_kept", {8'h00, din}, 16'h00A5);

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule
